vend_frontend: RTL and testbench
================================

VEND_FRONTEND -- requirements
Module: vend_frontend

Interface
REQ-001 SHALL: CLK  in  1  single clock; all state updates on posedge CLK.
REQ-002 SHALL: RST  in  1  reset, synchronous and active-high.
REQ-003 SHALL: coinValid  in  1; coinValue  in  2 (00=1, 01=5, 10=10, 11=20); one coin per cycle.
REQ-004 SHALL: select  in  1 purchase pulse; selVm  in  1; selProduct  in  3; selSugar  in  1 (customer choice).
REQ-005 SHALL: cancel  in  1  refund request.
REQ-006 SHALL: money  out  6; vm  out  1; productID  out  3; sugar  out  1; vendStrobe  out  1 (request to vending machine).
REQ-007 SHALL: respValid  in  1; moneyLeft  in  6; productReady  in  1; rspFlags  in  5 = {productUnavailable, insufficientFund, notExactFund, invalidProduct, sugarUnsuitable}.
REQ-008 SHALL: credit  out  6; coinReject  out  1; coinReturn  out  1; returnValue  out  2 (coinValue encoding); dispensed  out  1; busy  out  1; errorCode  out  3.

Function
REQ-009 SHALL: FSM states IDLE, REQ, WAIT, CHANGE; busy=1 in any state other than IDLE.
REQ-010 SHALL: IDLE, coinValid, credit+value<=63 -> credit+=value next cycle; otherwise coinReject pulses 1 cycle and credit is unchanged.
REQ-011 SHALL: coinValid outside IDLE -> coinReject pulse; coin ignored.
REQ-012 SHALL: IDLE, select at cycle N -> latch money=credit, vm, productID, sugar; state REQ with vendStrobe=1 during N+1 only; WAIT from N+2.
REQ-013 SHALL: money/vm/productID/sugar held stable from N+1 until response accepted or timeout.
REQ-014 SHALL: respValid is sampled only in WAIT and ignored in every other state.
REQ-015 SHALL: WAIT, respValid, productReady=1 -> dispensed pulse 1 cycle; credit=0; errorCode=000; remaining=moneyLeft; go CHANGE if moneyLeft>0, else IDLE.
REQ-016 SHALL: WAIT, respValid, productReady=0 -> credit=moneyLeft; errorCode latched by priority unavailable=001 > insufficient=010 > notExact=011 > invalid=100 > sugar=101; flags all 0 -> 111; go IDLE.
REQ-017 SHALL: errorCode holds until the next accepted response, timeout, or reset; a new select does not clear it.
REQ-018 SHALL: IDLE, cancel, credit>0 -> remaining=credit, credit=0, go CHANGE; cancel with credit=0 or outside IDLE ignored.
REQ-019 SHALL: IDLE, select and cancel in the same cycle -> cancel wins; select or cancel together with coinValid -> coin rejected.
REQ-020 SHALL: CHANGE emits one coin per cycle (coinReturn=1), greedy largest of 20,10,5,1 <= remaining; remaining decrements; IDLE the cycle after remaining reaches 0.
REQ-021 SHALL: credit is 6-bit, never wraps (REQ-010); remaining arithmetic never underflows.

Reset
REQ-022 SHALL: RST=1 at a posedge -> state IDLE; credit, remaining, timeout counter, errorCode, and all outputs 0.
REQ-023 SHALL: reset mid-REQ/WAIT/CHANGE aborts the operation; undispensed change and pending request are discarded.

Configuration
REQ-024 SHALL: with VEND_TIMEOUT_EN defined, a 4-bit counter counts WAIT cycles; 16 WAIT cycles without respValid -> errorCode=110, remaining=latched money, credit=0, go CHANGE (IDLE if money=0).
REQ-025 SHALL: if respValid arrives in the timeout cycle, the response wins.
REQ-026 SHALL: with VEND_TIMEOUT_EN undefined, no counter exists and WAIT persists until respValid.

Verification
REQ-027 SHALL: coins 20,10,5 then select(vm=1,id=011); response ready, moneyLeft=23 -> dispensed pulse, coinReturn 20,1,1,1 over 4 cycles, credit=0.
REQ-028 SHALL: credit 60, coin 5 -> coinReject=1, credit stays 60; coin 1 -> credit 61.
REQ-029 SHALL: credit 15, select(vm=0,id=000); response not ready, notExactFund=1, moneyLeft=15 -> errorCode=011, credit=15, IDLE.
REQ-030 SHALL: credit 37, cancel -> coinReturn 20,10,5,1,1 over 5 cycles, then IDLE.
REQ-031 SHALL: VEND_TIMEOUT_EN defined, credit 8, select, no respValid -> 16 WAIT cycles, errorCode=110, refund 5,1,1,1.
REQ-032 SHALL: RST during CHANGE of 37 after first coin -> next cycle IDLE, all outputs 0, no further coins.

Source files
------------

// File: rtl/vend_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_frontend : coin credit, purchase request/response and change dispense |
// | Optional VEND_TIMEOUT_EN adds a 16-cycle WAIT timeout.  Rev 1.0            |
// +----------------------------------------------------------------------------+
module vend_frontend (
  input  logic       CLK,
  input  logic       RST,
  input  logic       coinValid,
  input  logic [1:0] coinValue,
  input  logic       select,
  input  logic       selVm,
  input  logic [2:0] selProduct,
  input  logic       selSugar,
  input  logic       cancel,
  output logic [5:0] money,
  output logic       vm,
  output logic [2:0] productID,
  output logic       sugar,
  output logic       vendStrobe,
  input  logic       respValid,
  input  logic [5:0] moneyLeft,
  input  logic       productReady,
  input  logic [4:0] rspFlags,
  output logic [5:0] credit,
  output logic       coinReject,
  output logic       coinReturn,
  output logic [1:0] returnValue,
  output logic       dispensed,
  output logic       busy,
  output logic [2:0] errorCode
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CHANGE} state_t;

  localparam logic [2:0] c_ERR_NONE    = 3'b000;
  localparam logic [2:0] c_ERR_TIMEOUT = 3'b110;
  localparam logic [2:0] c_ERR_NOFLAG  = 3'b111;

  state_t     r_state, w_stateNext;
  logic [5:0] r_credit, w_creditNext;
  logic [5:0] r_remaining, w_remainingNext;
  logic [2:0] r_errorCode, w_errorNext;
  logic [5:0] r_money;
  logic       r_vm, r_sugar, r_coinReject, r_dispensed;
  logic [2:0] r_productID;
  logic       w_latch, w_coinRejectNext, w_dispensedNext;
  logic [4:0] w_coinAmt, w_chgAmt;
  logic [1:0] w_chgCode;
  logic [6:0] w_sum;
`ifdef VEND_TIMEOUT_EN
  logic [3:0] r_timer, w_timerNext;
`endif

  always_comb begin
    case (coinValue)
      2'b00:   w_coinAmt = 5'd1;
      2'b01:   w_coinAmt = 5'd5;
      2'b10:   w_coinAmt = 5'd10;
      default: w_coinAmt = 5'd20;
    endcase
    w_sum = {1'b0, r_credit} + {2'b00, w_coinAmt};

    // Greedy change: largest denomination not exceeding what is still owed
    if (r_remaining >= 6'd20)      begin w_chgAmt = 5'd20; w_chgCode = 2'b11; end
    else if (r_remaining >= 6'd10) begin w_chgAmt = 5'd10; w_chgCode = 2'b10; end
    else if (r_remaining >= 6'd5)  begin w_chgAmt = 5'd5;  w_chgCode = 2'b01; end
    else                           begin w_chgAmt = 5'd1;  w_chgCode = 2'b00; end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_creditNext     = r_credit;
    w_remainingNext  = r_remaining;
    w_errorNext      = r_errorCode;
    w_latch          = 1'b0;
    w_coinRejectNext = coinValid;
    w_dispensedNext  = 1'b0;
`ifdef VEND_TIMEOUT_EN
    w_timerNext      = r_timer;
`endif
    case (r_state)
      S_IDLE: begin
        if (coinValid && !select && !cancel && !w_sum[6]) begin
          w_coinRejectNext = 1'b0;
          w_creditNext     = w_sum[5:0];
        end
        if (cancel) begin
          if (r_credit != 6'd0) begin
            w_remainingNext = r_credit;
            w_creditNext    = 6'd0;
            w_stateNext     = S_CHANGE;
          end
        end else if (select) begin
          w_latch     = 1'b1;
          w_stateNext = S_REQ;
        end
      end
      S_REQ: begin
`ifdef VEND_TIMEOUT_EN
        w_timerNext = 4'd0;
`endif
        w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (respValid) begin
          if (productReady) begin
            w_dispensedNext = 1'b1;
            w_creditNext    = 6'd0;
            w_errorNext     = c_ERR_NONE;
            w_remainingNext = moneyLeft;
            w_stateNext     = (moneyLeft != 6'd0) ? S_CHANGE : S_IDLE;
          end else begin
            w_creditNext = moneyLeft;
            if (rspFlags[4])      w_errorNext = 3'b001;
            else if (rspFlags[3]) w_errorNext = 3'b010;
            else if (rspFlags[2]) w_errorNext = 3'b011;
            else if (rspFlags[1]) w_errorNext = 3'b100;
            else if (rspFlags[0]) w_errorNext = 3'b101;
            else                  w_errorNext = c_ERR_NOFLAG;
            w_stateNext = S_IDLE;
          end
        end
`ifdef VEND_TIMEOUT_EN
        else if (r_timer == 4'hF) begin
          w_errorNext     = c_ERR_TIMEOUT;
          w_remainingNext = r_money;
          w_creditNext    = 6'd0;
          w_stateNext     = (r_money != 6'd0) ? S_CHANGE : S_IDLE;
        end else begin
          w_timerNext = r_timer + 4'd1;
        end
`endif
      end
      default: begin
        // CHANGE is only entered with a non-zero amount, so this cannot underflow
        w_remainingNext = r_remaining - {1'b0, w_chgAmt};
        if (r_remaining == {1'b0, w_chgAmt}) w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_credit     <= 6'd0;
      r_remaining  <= 6'd0;
      r_errorCode  <= 3'd0;
      r_money      <= 6'd0;
      r_vm         <= 1'b0;
      r_productID  <= 3'd0;
      r_sugar      <= 1'b0;
      r_coinReject <= 1'b0;
      r_dispensed  <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      r_timer      <= 4'd0;
`endif
    end else begin
      r_state      <= w_stateNext;
      r_credit     <= w_creditNext;
      r_remaining  <= w_remainingNext;
      r_errorCode  <= w_errorNext;
      r_coinReject <= w_coinRejectNext;
      r_dispensed  <= w_dispensedNext;
`ifdef VEND_TIMEOUT_EN
      r_timer      <= w_timerNext;
`endif
      if (w_latch) begin
        r_money     <= r_credit;
        r_vm        <= selVm;
        r_productID <= selProduct;
        r_sugar     <= selSugar;
      end
    end
  end

  assign money       = r_money;
  assign vm          = r_vm;
  assign productID   = r_productID;
  assign sugar       = r_sugar;
  assign vendStrobe  = (r_state == S_REQ);
  assign credit      = r_credit;
  assign coinReject  = r_coinReject;
  assign coinReturn  = (r_state == S_CHANGE);
  assign returnValue = (r_state == S_CHANGE) ? w_chgCode : 2'b00;
  assign dispensed   = r_dispensed;
  assign busy        = (r_state != S_IDLE);
  assign errorCode   = r_errorCode;

endmodule
`default_nettype wire

// File: tb/tb_vend_frontend.sv
`default_nettype none
// Directed self-checking bench for vend_frontend.
module tb_vend_frontend;

  logic       CLK = 1'b0;
  logic       RST;
  logic       coinValid, select, selVm, selSugar, cancel;
  logic [1:0] coinValue;
  logic [2:0] selProduct;
  logic [5:0] money, moneyLeft, credit;
  logic       vm, sugar, vendStrobe, respValid, productReady;
  logic [2:0] productID, errorCode;
  logic [4:0] rspFlags;
  logic       coinReject, coinReturn, dispensed, busy;
  logic [1:0] returnValue;

  int nCmp = 0;
  int nErr = 0;

  vend_frontend dut (
    .CLK(CLK), .RST(RST),
    .coinValid(coinValid), .coinValue(coinValue),
    .select(select), .selVm(selVm), .selProduct(selProduct), .selSugar(selSugar),
    .cancel(cancel),
    .money(money), .vm(vm), .productID(productID), .sugar(sugar), .vendStrobe(vendStrobe),
    .respValid(respValid), .moneyLeft(moneyLeft), .productReady(productReady), .rspFlags(rspFlags),
    .credit(credit), .coinReject(coinReject), .coinReturn(coinReturn), .returnValue(returnValue),
    .dispensed(dispensed), .busy(busy), .errorCode(errorCode)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic [1:0] v);
    coinValid = 1'b1;
    coinValue = v;
    tick;
    coinValid = 1'b0;
  endtask

  task automatic chgStep(input string tag, input logic [1:0] v);
    chk({tag, "_ret"}, coinReturn, 1);
    chk({tag, "_val"}, returnValue, v);
    tick;
  endtask

  task automatic purchase(input logic v, input logic [2:0] id);
    select = 1'b1; selVm = v; selProduct = id; selSugar = 1'b0;
    tick;
    select = 1'b0;
    tick;
  endtask

  task automatic respond(input logic rdy, input logic [4:0] f, input logic [5:0] left);
    respValid = 1'b1; productReady = rdy; rspFlags = f; moneyLeft = left;
    tick;
    respValid = 1'b0; productReady = 1'b0; rspFlags = 5'd0; moneyLeft = 6'd0;
  endtask

  initial begin
    RST = 1'b1; coinValid = 0; coinValue = 0; select = 0; selVm = 0; selProduct = 0;
    selSugar = 0; cancel = 0; respValid = 0; moneyLeft = 0; productReady = 0; rspFlags = 0;
    tick; tick;
    RST = 1'b0;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", errorCode, 0);
    chk("rst_money", money, 0);
    chk("rst_strobe", vendStrobe, 0);
    chk("rst_ret", coinReturn, 0);

    // Purchase with change: 20+10+5, dispense, 23 back as 20,1,1,1
    coin(2'b11); chk("c20", credit, 20); chk("c20_rej", coinReject, 0);
    coin(2'b10); chk("c30", credit, 30);
    coin(2'b01); chk("c35", credit, 35);
    select = 1'b1; selVm = 1'b1; selProduct = 3'd3; selSugar = 1'b1;
    tick;
    select = 1'b0;
    chk("req_strobe", vendStrobe, 1);
    chk("req_money", money, 35);
    chk("req_vm", vm, 1);
    chk("req_id", productID, 3);
    chk("req_sugar", sugar, 1);
    respValid = 1'b1; productReady = 1'b1; moneyLeft = 6'd0;
    tick;
    respValid = 1'b0; productReady = 1'b0;
    chk("wait_strobe", vendStrobe, 0);
    chk("wait_busy", busy, 1);
    chk("req_resp_ignored", dispensed, 0);
    chk("wait_money", money, 35);
    coin(2'b00);
    chk("wait_coin_rej", coinReject, 1);
    chk("wait_coin_credit", credit, 35);
    respond(1'b1, 5'd0, 6'd23);
    chk("disp", dispensed, 1);
    chk("disp_credit", credit, 0);
    chk("disp_err", errorCode, 0);
    chgStep("ch23_0", 2'b11);
    chk("disp_pulse", dispensed, 0);
    chgStep("ch23_1", 2'b00);
    chgStep("ch23_2", 2'b00);
    chgStep("ch23_3", 2'b00);
    chk("ch23_idle", busy, 0);
    chk("ch23_noret", coinReturn, 0);

    // Credit ceiling at 63
    coin(2'b11); coin(2'b11); coin(2'b11);
    chk("c60", credit, 60);
    coin(2'b01); chk("ovf_rej", coinReject, 1); chk("ovf_credit", credit, 60);
    coin(2'b00); chk("c61_rej", coinReject, 0); chk("c61", credit, 61);
    coin(2'b00); coin(2'b00); chk("c63", credit, 63);
    coin(2'b00); chk("c63_rej", coinReject, 1); chk("c63_keep", credit, 63);

    // Cancel with a coin: coin rejected, 63 back as 20,20,20,1,1,1
    cancel = 1'b1; coinValid = 1'b1; coinValue = 2'b00;
    tick;
    cancel = 1'b0; coinValid = 1'b0;
    chk("cxl_rej", coinReject, 1);
    chk("cxl_credit", credit, 0);
    chgStep("ch63_0", 2'b11);
    chgStep("ch63_1", 2'b11);
    chgStep("ch63_2", 2'b11);
    chgStep("ch63_3", 2'b00);
    chgStep("ch63_4", 2'b00);
    chgStep("ch63_5", 2'b00);
    chk("ch63_idle", busy, 0);

    // Failed purchase, error priority and hold across select
    coin(2'b10); coin(2'b01);
    purchase(1'b0, 3'd0);
    chk("f_money", money, 15);
    chk("f_vm", vm, 0);
    respond(1'b0, 5'b00100, 6'd15);
    chk("f_err3", errorCode, 3);
    chk("f_credit", credit, 15);
    chk("f_idle", busy, 0);
    chk("f_nodisp", dispensed, 0);
    select = 1'b1; tick; select = 1'b0;
    chk("f_err_hold", errorCode, 3);
    tick;
    respond(1'b0, 5'b11111, 6'd15);
    chk("f_err1", errorCode, 1);
    purchase(1'b0, 3'd1);
    respond(1'b0, 5'b00000, 6'd15);
    chk("f_err7", errorCode, 7);
    purchase(1'b0, 3'd1);
    respond(1'b0, 5'b01010, 6'd15);
    chk("f_err2", errorCode, 2);
    purchase(1'b0, 3'd1);
    respond(1'b0, 5'b00011, 6'd15);
    chk("f_err4", errorCode, 4);
    purchase(1'b0, 3'd1);
    respond(1'b0, 5'b00001, 6'd12);
    chk("f_err5", errorCode, 5);
    chk("f_credit12", credit, 12);

    // Cancel 37 -> 20,10,5,1,1
    coin(2'b11); coin(2'b01);
    chk("c37", credit, 37);
    cancel = 1'b1; tick; cancel = 1'b0;
    chgStep("ch37_0", 2'b11);
    chgStep("ch37_1", 2'b10);
    chgStep("ch37_2", 2'b01);
    chgStep("ch37_3", 2'b00);
    chgStep("ch37_4", 2'b00);
    chk("ch37_idle", busy, 0);
    chk("ch37_val0", returnValue, 0);
    cancel = 1'b1; tick; cancel = 1'b0;
    chk("cxl0_ignored", busy, 0);

    // Reset in the middle of a 37 refund
    coin(2'b11); coin(2'b10); coin(2'b01); coin(2'b00); coin(2'b00);
    cancel = 1'b1; tick; cancel = 1'b0;
    chgStep("rc_0", 2'b11);
    RST = 1'b1; tick; RST = 1'b0;
    chk("rc_busy", busy, 0);
    chk("rc_ret", coinReturn, 0);
    chk("rc_credit", credit, 0);
    chk("rc_err", errorCode, 0);
    chk("rc_money", money, 0);
    tick;
    chk("rc_noret", coinReturn, 0);

    // WAIT with no response
    coin(2'b01); coin(2'b00); coin(2'b00); coin(2'b00);
    chk("c8", credit, 8);
    purchase(1'b1, 3'd2);
    for (int i = 1; i < 16; i++) tick;
    chk("w16_busy", busy, 1);
    chk("w16_ret", coinReturn, 0);
`ifdef VEND_TIMEOUT_EN
    tick;
    chk("to_err", errorCode, 6);
    chk("to_credit", credit, 0);
    chgStep("to_0", 2'b01);
    chgStep("to_1", 2'b00);
    chgStep("to_2", 2'b00);
    chgStep("to_3", 2'b00);
    chk("to_idle", busy, 0);
`else
    for (int i = 0; i < 10; i++) tick;
    chk("nto_busy", busy, 1);
    chk("nto_err", errorCode, 0);
    respond(1'b1, 5'd0, 6'd0);
    chk("nto_disp", dispensed, 1);
    chk("nto_idle", busy, 0);
    chk("nto_credit", credit, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
